// File: rtl/seg7_scan_driver.sv
// Four-digit seven-segment driver: latches a signed result, converts it to BCD
// with a sequential double-dabble FSM, formats sign/blanking/error, and scans digits.
module seg7_scan_driver #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        CLK_100MHz,
  input  logic        RST,
  input  logic        i_led_clk,
  input  logic        i_load,
  input  logic [15:0] i_value,
  input  logic        i_blank,
  output logic        o_busy,
  output logic [3:0]  o_an,
  output logic [6:0]  o_seg,
  output logic        o_dp
);

  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FORMAT} state_t;

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    seg_digit = 7'b1000000;
      4'd1:    seg_digit = 7'b1111001;
      4'd2:    seg_digit = 7'b0100100;
      4'd3:    seg_digit = 7'b0110000;
      4'd4:    seg_digit = 7'b0011001;
      4'd5:    seg_digit = 7'b0010010;
      4'd6:    seg_digit = 7'b0000010;
      4'd7:    seg_digit = 7'b1111000;
      4'd8:    seg_digit = 7'b0000000;
      4'd9:    seg_digit = 7'b0010000;
      default: seg_digit = SEG_BLANK;
    endcase
  endfunction

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   led_prev_q, led_prev_d;
  logic                   scan_tick;
  logic [1:0]             idx_q, idx_d;
  logic [3:0]             an_q, an_d;
  logic [6:0]             seg_q, seg_d;
  state_t                 state_q, state_d;
  logic [3:0]             count_q, count_d;
  logic                   sign_q, sign_d;
  logic [15:0]            mag_q, mag_d;
  logic [19:0]            bcd_q, bcd_d;
  logic                   busy_q, busy_d;
  logic [3:0][6:0]        disp_q, disp_d;

  logic [19:0]     bcd_adj;
  logic [3:0][3:0] dig;
  logic [3:0]      lead;
  logic            err;
  logic [3:0][6:0] fmt;

  // Scan path: synchroniser, rising-edge detect, digit index, registered outputs.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], i_led_clk};
    led_prev_d = sync_q[SYNC_STAGES-1];
    scan_tick  = sync_q[SYNC_STAGES-1] & ~led_prev_q;
    idx_d      = scan_tick ? idx_q + 2'd1 : idx_q;
    an_d       = i_blank ? 4'b1111 : ~(4'b0001 << idx_q);
    seg_d      = disp_q[idx_q];
  end

  // Formatting of the completed BCD result; lead[k] means some digit at k or above is non-zero.
  always_comb begin
    for (int unsigned k = 0; k < 4; k++) dig[k] = bcd_q[4*k +: 4];
    lead[3] = |dig[3];
    lead[2] = lead[3] | (|dig[2]);
    lead[1] = lead[2] | (|dig[1]);
    lead[0] = lead[1] | (|dig[0]);
    err     = (|bcd_q[19:16]) | (sign_q & (|dig[3]));
    fmt[0]  = seg_digit(dig[0]);
    for (int unsigned k = 1; k < 4; k++) begin
      if (lead[k])                fmt[k] = seg_digit(dig[k]);
      else if (sign_q && lead[k-1]) fmt[k] = SEG_MINUS;
      else                        fmt[k] = SEG_BLANK;
    end
    if (err) fmt = {SEG_E, SEG_R, SEG_R, SEG_BLANK};
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    busy_d  = busy_q;
    disp_d  = disp_q;
    bcd_adj = bcd_q;
    for (int unsigned k = 0; k < 5; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
    unique case (state_q)
      S_IDLE: begin
        if (i_load) begin
          sign_d  = i_value[15];
          mag_d   = i_value[15] ? (~i_value + 16'd1) : i_value;
          bcd_d   = '0;
          count_d = '0;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        bcd_d   = {bcd_adj[18:0], mag_q[15]};
        mag_d   = {mag_q[14:0], 1'b0};
        count_d = count_q + 4'd1;
        if (count_q == 4'd15) state_d = S_FORMAT;
      end
      S_FORMAT: begin
        disp_d  = fmt;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_100MHz or posedge RST) begin
    if (RST) begin
      sync_q     <= '0;
      led_prev_q <= 1'b0;
      idx_q      <= '0;
      an_q       <= '1;
      seg_q      <= '1;
      state_q    <= S_IDLE;
      count_q    <= '0;
      sign_q     <= 1'b0;
      mag_q      <= '0;
      bcd_q      <= '0;
      busy_q     <= 1'b0;
      disp_q     <= {SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_ZERO};
    end else begin
      sync_q     <= sync_d;
      led_prev_q <= led_prev_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      state_q    <= state_d;
      count_q    <= count_d;
      sign_q     <= sign_d;
      mag_q      <= mag_d;
      bcd_q      <= bcd_d;
      busy_q     <= busy_d;
      disp_q     <= disp_d;
    end
  end

  assign o_busy = busy_q;
  assign o_an   = SEG_ACTIVE_LOW ? an_q  : ~an_q;
  assign o_seg  = SEG_ACTIVE_LOW ? seg_q : ~seg_q;
  assign o_dp   = SEG_ACTIVE_LOW;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: scan timing, conversion latency, formatting, blanking.
module tb_seg7_scan_driver;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S9 = 7'b0010000;
  localparam logic [6:0] SE = 7'b0000110, SR = 7'b0101111, SM = 7'b0111111,
                         SB = 7'b1111111;

  logic        CLK_100MHz = 1'b0;
  logic        RST = 1'b1;
  logic        i_led_clk = 1'b0;
  logic        i_load = 1'b0;
  logic [15:0] i_value = '0;
  logic        i_blank = 1'b0;
  logic        o_busy;
  logic [3:0]  o_an;
  logic [6:0]  o_seg;
  logic        o_dp;

  int unsigned checks = 0;
  int unsigned passed = 0;
  int unsigned failed = 0;
  logic [1:0]  exp_idx = 2'd0;
  int unsigned nb;

  seg7_scan_driver #(.SYNC_STAGES(2), .SEG_ACTIVE_LOW(1'b1)) dut (
    .CLK_100MHz(CLK_100MHz), .RST(RST), .i_led_clk(i_led_clk),
    .i_load(i_load), .i_value(i_value), .i_blank(i_blank),
    .o_busy(o_busy), .o_an(o_an), .o_seg(o_seg), .o_dp(o_dp)
  );

  always #5 CLK_100MHz = ~CLK_100MHz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge on i_led_clk; o_an reflects the new index 4 cycles later.
  task automatic step_digit();
    i_led_clk = 1'b1;
    repeat (4) @(negedge CLK_100MHz);
    exp_idx = exp_idx + 2'd1;
    i_led_clk = 1'b0;
    repeat (2) @(negedge CLK_100MHz);
  endtask

  task automatic check_display(input string tag, input logic [6:0] d3, input logic [6:0] d2,
                               input logic [6:0] d1, input logic [6:0] d0);
    logic [6:0] e [4];
    logic [3:0] ea;
    e[0] = d0; e[1] = d1; e[2] = d2; e[3] = d3;
    for (int i = 0; i < 4; i++) begin
      step_digit();
      ea = ~(4'b0001 << exp_idx);
      check({tag, "_an"}, {28'd0, o_an}, {28'd0, ea});
      check($sformatf("%s_d%0d", tag, exp_idx), {25'd0, o_seg}, {25'd0, e[exp_idx]});
    end
  endtask

  task automatic do_load(input logic [15:0] v, output int unsigned n);
    i_value = v;
    i_load = 1'b1;
    @(negedge CLK_100MHz);
    i_load = 1'b0;
    n = 0;
    while (o_busy === 1'b1 && n < 40) begin
      n++;
      @(negedge CLK_100MHz);
    end
  endtask

  initial begin
    repeat (3) @(negedge CLK_100MHz);
    check("rst_an", {28'd0, o_an}, 32'hF);
    check("rst_seg", {25'd0, o_seg}, 32'h7F);
    check("rst_dp", {31'd0, o_dp}, 32'd1);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    RST = 1'b0;
    @(negedge CLK_100MHz);
    check("post_rst_an", {28'd0, o_an}, 32'hE);
    check("post_rst_seg", {25'd0, o_seg}, {25'd0, S0});
    check("post_rst_busy", {31'd0, o_busy}, 32'd0);

    // First scan edge: unchanged after 3 cycles, advanced after 4.
    i_led_clk = 1'b1;
    repeat (3) @(negedge CLK_100MHz);
    check("scan_early", {28'd0, o_an}, 32'hE);
    @(negedge CLK_100MHz);
    check("scan_edge1", {28'd0, o_an}, 32'hD);
    exp_idx = 2'd1;
    i_led_clk = 1'b0;
    repeat (2) @(negedge CLK_100MHz);
    step_digit(); check("scan_edge2", {28'd0, o_an}, 32'hB);
    step_digit(); check("scan_edge3", {28'd0, o_an}, 32'h7);
    step_digit(); check("scan_wrap", {28'd0, o_an}, 32'hE);

    do_load(16'd1234, nb);
    check("busy_1234", nb, 32'd17);
    check_display("v1234", S1, S2, S3, S4);

    do_load(16'hFFFB, nb);
    check_display("vm5", SB, SB, SM, S5);
    do_load(16'hFC19, nb);
    check_display("vm999", SM, S9, S9, S9);
    do_load(16'd10000, nb);
    check_display("v10000", SE, SR, SR, SB);
    do_load(16'hFC18, nb);
    check_display("vm1000", SE, SR, SR, SB);
    do_load(16'h8000, nb);
    check("busy_m32768", nb, 32'd17);
    check_display("vm32768", SE, SR, SR, SB);
    do_load(16'd0, nb);
    check_display("v0", SB, SB, SB, S0);

    // Second load 5 cycles into a conversion must be ignored.
    i_value = 16'd42;
    i_load = 1'b1;
    @(negedge CLK_100MHz);
    i_load = 1'b0;
    nb = 0;
    while (o_busy === 1'b1 && nb < 40) begin
      nb++;
      if (nb == 5) begin
        i_value = 16'd7777;
        i_load = 1'b1;
      end
      @(negedge CLK_100MHz);
      i_load = 1'b0;
    end
    check("busy_reload", nb, 32'd17);
    check_display("v42", SB, SB, S4, S2);

    // Reset in the middle of SHIFT.
    i_value = 16'd1234;
    i_load = 1'b1;
    @(negedge CLK_100MHz);
    i_load = 1'b0;
    repeat (5) @(negedge CLK_100MHz);
    check("mid_busy", {31'd0, o_busy}, 32'd1);
    RST = 1'b1;
    @(negedge CLK_100MHz);
    check("midrst_busy", {31'd0, o_busy}, 32'd0);
    check("midrst_an", {28'd0, o_an}, 32'hF);
    RST = 1'b0;
    exp_idx = 2'd0;
    @(negedge CLK_100MHz);
    check("midrst_rel_an", {28'd0, o_an}, 32'hE);
    check("midrst_rel_seg", {25'd0, o_seg}, {25'd0, S0});
    repeat (20) @(negedge CLK_100MHz);
    check("midrst_idle", {31'd0, o_busy}, 32'd0);
    check_display("vrst", SB, SB, SB, S0);

    // Blanking keeps scanning underneath.
    i_blank = 1'b1;
    @(negedge CLK_100MHz);
    check("blank_an", {28'd0, o_an}, 32'hF);
    step_digit(); check("blank_step1", {28'd0, o_an}, 32'hF);
    step_digit(); check("blank_step2", {28'd0, o_an}, 32'hF);
    i_blank = 1'b0;
    @(negedge CLK_100MHz);
    check("unblank_an", {28'd0, o_an}, {28'd0, ~(4'b0001 << exp_idx)});
    check("unblank_idx", {30'd0, exp_idx}, 32'd2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
